// File: rtl/bitser_mac_pkg.sv
// Shared types and default sizing for the bit-serial MAC unit.
// BITSER_MAC_SAT_EN selects saturating rather than wrapping result narrowing.
package bitser_mac_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_VEC_LENGTH = 16;
  localparam int DEF_W_MAX      = 8;

  localparam int PSUM_WIDTH = DEF_DATA_WIDTH + 1 + $clog2(DEF_VEC_LENGTH);
  localparam int COL_WIDTH  = $clog2(DEF_W_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/bitser_mac_unit_adder_tree.sv
// Combinational balanced adder tree; every level carries the full output width
// so sign growth across all log2(N) levels is exact.
module bitser_adder_tree #(
  parameter int N     = 16,
  parameter int IN_W  = 9,
  parameter int OUT_W = IN_W + $clog2(N)
) (
  input  logic [N-1:0][IN_W-1:0] in_i,
  output logic signed [OUT_W-1:0] sum_o
);

  localparam int LEVELS = $clog2(N);

  for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_lvl
    localparam int CNT = N >> gi;
    logic signed [OUT_W-1:0] s [CNT];
    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < CNT; gj++) begin : g_ext
        assign s[gj] = {{(OUT_W-IN_W){in_i[gj][IN_W-1]}}, in_i[gj]};
      end
    end else begin : g_node
      for (genvar gj = 0; gj < CNT; gj++) begin : g_add
        assign s[gj] = g_lvl[gi-1].s[2*gj] + g_lvl[gi-1].s[2*gj+1];
      end
    end
  end

  assign sum_o = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/bitser_mac_unit.sv
// Bit-serial weight MAC: one weight bit-column per accepted beat, MSB first.
// Define BITSER_MAC_SAT_EN to saturate the accumulator into the result range.
module bitser_mac_unit
  import bitser_mac_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VEC_LENGTH   = DEF_VEC_LENGTH,
  parameter int W_MAX        = DEF_W_MAX,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter int ACC_WIDTH    = DATA_WIDTH + $clog2(VEC_LENGTH) + W_MAX + 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
  input  logic [VEC_LENGTH-1:0]                 sign,
  input  logic [VEC_LENGTH-1:0]                 w_bit,
  input  logic [$clog2(W_MAX)-1:0]              cfg_prec,
  input  logic                                  cfg_load_prev,
  input  logic                                  cfg_pool,
  input  logic [RESULT_WIDTH-1:0]               result_prev,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [RESULT_WIDTH-1:0]               result,
  output logic                                  busy
);

  localparam int PSUM_W = DATA_WIDTH + 1 + $clog2(VEC_LENGTH);
  localparam int COL_W  = $clog2(W_MAX);

  state_e                        state_q, state_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   s1_psum_q, s1_psum_d;
  logic                          s1_vld_q;
  logic                          pool_q, pool_d;

  logic [VEC_LENGTH-1:0][DATA_WIDTH:0] prod;
  logic signed [PSUM_W-1:0]      psum;
  logic signed [ACC_WIDTH-1:0]   psum_ext;
  logic signed [ACC_WIDTH-1:0]   prev_ext;
  logic [COL_W-1:0]              beat_col;
  logic                          accept;

  // Lane products are one bit wider than act so negating -2^(DW-1) is exact.
  for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
    logic [DATA_WIDTH:0] act_ext;
    assign act_ext  = {act[gi][DATA_WIDTH-1], act[gi]};
    assign prod[gi] = !w_bit[gi] ? '0 : (sign[gi] ? -act_ext : act_ext);
  end

  bitser_adder_tree #(
    .N     (VEC_LENGTH),
    .IN_W  (DATA_WIDTH + 1),
    .OUT_W (PSUM_W)
  ) u_tree (
    .in_i  (prod),
    .sum_o (psum)
  );

  assign in_ready = !reset && (state_q == IDLE || state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign psum_ext = {{(ACC_WIDTH-PSUM_W){psum[PSUM_W-1]}}, psum};
  assign prev_ext = {{(ACC_WIDTH-RESULT_WIDTH){result_prev[RESULT_WIDTH-1]}}, result_prev};
  // The first beat of a job takes its weight from cfg_prec before col_q is loaded.
  assign beat_col  = (state_q == IDLE) ? cfg_prec : col_q;
  assign s1_psum_d = psum_ext <<< beat_col;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pool_d  = pool_q;
    acc_d   = s1_vld_q ? (acc_q + s1_psum_q) : acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pool_d  = cfg_pool;
          col_d   = cfg_prec - 1'b1;
          acc_d   = cfg_load_prev ? prev_ext : '0;
          state_d = (cfg_prec == '0) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          col_d = col_q - 1'b1;
          if (col_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: state_d = OUT;
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      acc_q     <= '0;
      s1_psum_q <= '0;
      s1_vld_q  <= 1'b0;
      pool_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      acc_q     <= acc_d;
      s1_psum_q <= s1_psum_d;
      s1_vld_q  <= accept;
      pool_q    <= pool_d;
    end
  end

  logic signed [RESULT_WIDTH-1:0] acc_res;
  logic signed [RESULT_WIDTH-1:0] final_res;

`ifdef BITSER_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

  always_comb begin
    acc_res = acc_q[RESULT_WIDTH-1:0];
    if (acc_q > SAT_MAX)      acc_res = SAT_MAX[RESULT_WIDTH-1:0];
    else if (acc_q < SAT_MIN) acc_res = SAT_MIN[RESULT_WIDTH-1:0];
  end
`else
  assign acc_res = acc_q[RESULT_WIDTH-1:0];
`endif

  // Pooling compares against the live result_prev while the result is presented.
  assign final_res = (pool_q && ($signed(result_prev) > acc_res)) ? result_prev : acc_res;
  assign out_valid = (state_q == OUT);
  assign result    = (state_q == OUT) ? final_res : '0;

endmodule
